// File: rtl/psram_pkg.sv
// Shared PSRAM types: byte address, pending request record, arbiter states.
// Used by psram_access_arbiter and its round-robin picker.
package psram_pkg;

    localparam int PSRAM_ADDR_W = 23;

    typedef logic [PSRAM_ADDR_W-1:0] psram_addr_t;

    typedef struct packed {
        psram_addr_t addr;
        logic [7:0]  wdata;
        logic        is_write;
    } psram_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } arb_state_t;

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psram_access_arbiter_if.sv
// Client ports plus the shared PSRAM host port of psram_access_arbiter.
// slave = arbiter side, master = requesters and controller side.
interface psram_access_arbiter_if
    import psram_pkg::*;
#(
    parameter int NUM_CLIENTS = 3
);

    psram_addr_t [NUM_CLIENTS-1:0] i_ADDR;
    logic [NUM_CLIENTS-1:0]        i_WRITE;
    logic [NUM_CLIENTS-1:0]        i_READ;
    logic [NUM_CLIENTS-1:0][7:0]   i_WDATA;
    logic [NUM_CLIENTS-1:0][7:0]   o_RDATA;
    logic [NUM_CLIENTS-1:0]        o_BUSY;

    psram_addr_t o_HOST_ADDR;
    logic        o_HOST_WRITE;
    logic        o_HOST_READ;
    logic [7:0]  o_HOST_WDATA;
    logic [7:0]  i_HOST_RDATA;
    logic        i_HOST_BUSY;

    modport slave (
        input  i_ADDR,
        input  i_WRITE,
        input  i_READ,
        input  i_WDATA,
        output o_RDATA,
        output o_BUSY,
        output o_HOST_ADDR,
        output o_HOST_WRITE,
        output o_HOST_READ,
        output o_HOST_WDATA,
        input  i_HOST_RDATA,
        input  i_HOST_BUSY
    );

    modport master (
        output i_ADDR,
        output i_WRITE,
        output i_READ,
        output i_WDATA,
        input  o_RDATA,
        input  o_BUSY,
        input  o_HOST_ADDR,
        input  o_HOST_WRITE,
        input  o_HOST_READ,
        input  o_HOST_WDATA,
        output i_HOST_RDATA,
        output i_HOST_BUSY
    );

endinterface

// File: rtl/psram_rr_pick.sv
// Winner selection over the pending mask. Round-robin after last_grant,
// or lowest-index-first when PSRAM_ARB_FIXED_PRIORITY_EN is defined.
module psram_rr_pick
    import psram_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    localparam int IW = idx_w(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] pending,
    input  logic [IW-1:0]          last_grant,
    output logic [IW-1:0]          win,
    output logic                   valid
);

`ifdef PSRAM_ARB_FIXED_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                valid = 1'b1;
                win   = IW'(i);
            end
        end
    end
`else
    // Scan backwards so the client closest after last_grant wins.
    always_comb begin
        int idx;
        idx   = 0;
        valid = 1'b0;
        win   = '0;
        for (int i = NUM_CLIENTS; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NUM_CLIENTS;
            if (pending[idx]) begin
                valid = 1'b1;
                win   = IW'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/psram_access_arbiter.sv
// Shares one PSRAM byte-access port among NUM_CLIENTS requesters.
// Define PSRAM_ARB_FIXED_PRIORITY_EN for fixed priority instead of round-robin.
module psram_access_arbiter
    import psram_pkg::*;
#(
    parameter int NUM_CLIENTS = 3
) (
    input logic                  i_CLK,
    input logic                  i_RST,
    psram_access_arbiter_if.slave bus
);

    localparam int IW = idx_w(NUM_CLIENTS);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_CLIENTS - 1);

    arb_state_t state_q;
    arb_state_t state_d;

    logic [IW-1:0] win_q;
    logic [IW-1:0] win_d;
    logic [IW-1:0] last_q;
    logic [IW-1:0] pick_win;
    logic          pick_valid;
    logic          done;
    logic          active;

    logic [NUM_CLIENTS-1:0]      pend_q;
    psram_req_t [NUM_CLIENTS-1:0] req_q;
    logic [NUM_CLIENTS-1:0][7:0] rdata_q;
    psram_req_t                  cur;

    psram_rr_pick #(
        .NUM_CLIENTS(NUM_CLIENTS)
    ) u_pick (
        .pending   (pend_q),
        .last_grant(last_q),
        .win       (pick_win),
        .valid     (pick_valid)
    );

    assign cur    = req_q[win_q];
    assign active = (state_q != IDLE);

    // Host address/data are held from the winner's pending slot,
    // which cannot change while that client is busy.
    assign bus.o_HOST_ADDR  = active ? cur.addr : '0;
    assign bus.o_HOST_WDATA = active ? cur.wdata : '0;
    assign bus.o_HOST_WRITE = (state_q == ISSUE) && cur.is_write;
    assign bus.o_HOST_READ  = (state_q == ISSUE) && !cur.is_write;

    assign bus.o_BUSY  = pend_q;
    assign bus.o_RDATA = rdata_q;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ISSUE;
                    win_d   = pick_win;
                end
            end
            ISSUE: state_d = WAIT_ACK;
            WAIT_ACK: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (!bus.i_HOST_BUSY) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= IDLE;
            win_q   <= '0;
            last_q  <= LAST_RST;
            pend_q  <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            if (done) begin
                last_q <= win_q;
            end
            for (int k = 0; k < NUM_CLIENTS; k++) begin
                if (done && win_q == IW'(k)) begin
                    pend_q[k] <= 1'b0;
                    if (!cur.is_write) begin
                        rdata_q[k] <= bus.i_HOST_RDATA;
                    end
                end
                // Strobes while busy are dropped; read+write counts as write.
                if (!pend_q[k] && (bus.i_READ[k] || bus.i_WRITE[k])) begin
                    pend_q[k]         <= 1'b1;
                    req_q[k].addr     <= bus.i_ADDR[k];
                    req_q[k].wdata    <= bus.i_WDATA[k];
                    req_q[k].is_write <= bus.i_WRITE[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Scoreboard bench for psram_access_arbiter with a PSRAM controller model.
// Directed vectors; a negedge monitor checks host accesses and completions.
module tb_psram_access_arbiter;
    import psram_pkg::*;

    localparam int N = 3;

    typedef struct {
        psram_addr_t addr;
        bit          wr;
        logic [7:0]  wd;
        int          cyc;
    } host_t;

    typedef struct {
        int         k;
        logic [7:0] data;
        int         lat;
        int         t0;
    } cpl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   in_rst = 1'b1;

    host_t hq[$];
    cpl_t  cq[$];
    logic [7:0] exp_rd [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psram_access_arbiter_if #(.NUM_CLIENTS(N)) bus ();

    psram_access_arbiter #(
        .NUM_CLIENTS(N)
    ) dut (
        .i_CLK(clk),
        .i_RST(rst),
        .bus  (bus)
    );

    // Controller model: busy from the cycle after a strobe for 4 cycles.
    logic [7:0] mem [4096];
    int         hcnt;
    logic [7:0] hrd;

    function automatic logic [7:0] init_val(int a);
        case (a)
            12'h345: return 8'hA5;
            12'h100: return 8'h11;
            12'h101: return 8'h22;
            12'h102: return 8'h33;
            12'h020: return 8'h44;
            12'h021: return 8'h4B;
            12'h200: return 8'h55;
            12'h201: return 8'h66;
            12'h202: return 8'h77;
            12'h300: return 8'h88;
            12'h301: return 8'h99;
            12'h302: return 8'h9A;
            12'h303: return 8'hAB;
            12'h304: return 8'hCD;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hcnt <= 0;
            hrd  <= 8'h00;
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
        end else if (bus.o_HOST_READ || bus.o_HOST_WRITE) begin
            hcnt <= 4;
            if (bus.o_HOST_WRITE)
                mem[bus.o_HOST_ADDR[11:0]] <= bus.o_HOST_WDATA;
            else
                hrd <= mem[bus.o_HOST_ADDR[11:0]];
        end else if (hcnt != 0) begin
            hcnt <= hcnt - 1;
        end
    end

    assign bus.i_HOST_BUSY  = (hcnt != 0);
    assign bus.i_HOST_RDATA = hrd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents an output.
    logic [N-1:0] pbusy = '0;
    always @(negedge clk) begin
        host_t h;
        cpl_t  c;
        if (bus.o_HOST_READ || bus.o_HOST_WRITE) begin
            if (hq.size() == 0) begin
                fail("host_unexpected_access");
            end else begin
                h = hq.pop_front();
                chk("host_addr", 32'(bus.o_HOST_ADDR), 32'(h.addr));
                chk("host_write", 32'(bus.o_HOST_WRITE), 32'(h.wr));
                chk("host_read", 32'(bus.o_HOST_READ), 32'(!h.wr));
                if (h.wr) chk("host_wdata", 32'(bus.o_HOST_WDATA), 32'(h.wd));
                if (h.cyc >= 0) chk("host_cycle", cyc, h.cyc);
            end
        end
        if (!in_rst) begin
            for (int k = 0; k < N; k++) begin
                if (pbusy[k] && !bus.o_BUSY[k]) begin
                    if (cq.size() == 0) begin
                        fail("unexpected_completion");
                    end else begin
                        c = cq.pop_front();
                        chk("grant_client", k, c.k);
                        chk("rdata", 32'(bus.o_RDATA[k]), 32'(c.data));
                        if (c.lat >= 0) chk("busy_latency", cyc - c.t0, c.lat);
                    end
                end
            end
        end
        pbusy <= bus.o_BUSY;
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        bus.i_READ  = '0;
        bus.i_WRITE = '0;
        bus.i_ADDR  = '0;
        bus.i_WDATA = '0;
    endtask

    task automatic req(int k, bit rd, bit wr, psram_addr_t a, logic [7:0] wd);
        bus.i_READ[k]  = rd;
        bus.i_WRITE[k] = wr;
        bus.i_ADDR[k]  = a;
        bus.i_WDATA[k] = wd;
    endtask

    task automatic expect_acc(int k, bit wr, psram_addr_t a, logic [7:0] wd,
                              logic [7:0] rdv, int lat, int t0, int hc);
        host_t h;
        cpl_t  c;
        h.addr = a;
        h.wr   = wr;
        h.wd   = wd;
        h.cyc  = hc;
        hq.push_back(h);
        if (!wr) exp_rd[k] = rdv;
        c.k    = k;
        c.data = exp_rd[k];
        c.lat  = lat;
        c.t0   = t0;
        cq.push_back(c);
    endtask

    task automatic wait_idle(string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (bus.o_BUSY == '0 && hq.size() == 0 && cq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail({name, "_timeout"});
            hq.delete();
            cq.delete();
        end
    endtask

    task automatic check_reset_state(string name);
        chk({name, "_busy"}, 32'(bus.o_BUSY), 0);
        chk({name, "_host_rd"}, 32'(bus.o_HOST_READ), 0);
        chk({name, "_host_wr"}, 32'(bus.o_HOST_WRITE), 0);
        chk({name, "_host_addr"}, 32'(bus.o_HOST_ADDR), 0);
        chk({name, "_host_wdata"}, 32'(bus.o_HOST_WDATA), 0);
        for (int k = 0; k < N; k++) chk({name, "_rdata"}, 32'(bus.o_RDATA[k]), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int k = 0; k < N; k++) exp_rd[k] = 8'h00;
        clear_all();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");
        go();
        in_rst = 1'b0;

        // Simultaneous requests, two rounds: 0,1,2 each time.
        for (int r = 0; r < 2; r++) begin
            go();
            t = cyc;
            for (int k = 0; k < N; k++) req(k, 1, 0, 23'h100 + 23'(k), 8'h00);
            expect_acc(0, 0, 23'h100, 8'h00, 8'h11, 8, t, t + 2);
            expect_acc(1, 0, 23'h101, 8'h00, 8'h22, 15, t, t + 9);
            expect_acc(2, 0, 23'h102, 8'h00, 8'h33, 22, t, t + 16);
            go();
            clear_all();
            wait_idle("simultaneous");
        end

        // Single read by client 1.
        go();
        t = cyc;
        req(1, 1, 0, 23'h12345, 8'h00);
        expect_acc(1, 0, 23'h12345, 8'h00, 8'hA5, 8, t, t + 2);
        go();
        clear_all();
        wait_idle("single_read");

        // Write then read of the same byte by another client.
        go();
        t = cyc;
        req(0, 0, 1, 23'h00010, 8'h3C);
        expect_acc(0, 1, 23'h00010, 8'h3C, 8'h00, 8, t, t + 2);
        go();
        clear_all();
        wait_idle("write");
        chk("mem_after_write", 32'(mem[12'h010]), 32'h3C);
        go();
        t = cyc;
        req(2, 1, 0, 23'h00010, 8'h00);
        expect_acc(2, 0, 23'h00010, 8'h00, 8'h3C, 8, t, t + 2);
        go();
        clear_all();
        wait_idle("read_back");

        // Strobe while busy is dropped.
        go();
        t = cyc;
        req(0, 1, 0, 23'h00020, 8'h00);
        expect_acc(0, 0, 23'h00020, 8'h00, 8'h44, 8, t, t + 2);
        go();
        clear_all();
        go();
        req(0, 1, 0, 23'h00021, 8'h00);
        go();
        clear_all();
        wait_idle("strobe_busy");

        // Read and write together is a write.
        go();
        t = cyc;
        req(1, 1, 1, 23'h00030, 8'h5A);
        expect_acc(1, 1, 23'h00030, 8'h5A, 8'h00, 8, t, t + 2);
        go();
        clear_all();
        wait_idle("read_write");
        chk("mem_rw_write", 32'(mem[12'h030]), 32'h5A);

        // last_grant is now 1.
        go();
        t = cyc;
        for (int k = 0; k < N; k++) req(k, 1, 0, 23'h200 + 23'(k), 8'h00);
`ifdef PSRAM_ARB_FIXED_PRIORITY_EN
        expect_acc(0, 0, 23'h200, 8'h00, 8'h55, 8, t, t + 2);
        expect_acc(1, 0, 23'h201, 8'h00, 8'h66, 15, t, t + 9);
        expect_acc(2, 0, 23'h202, 8'h00, 8'h77, 22, t, t + 16);
`else
        expect_acc(2, 0, 23'h202, 8'h00, 8'h77, 8, t, t + 2);
        expect_acc(0, 0, 23'h200, 8'h00, 8'h55, 15, t, t + 9);
        expect_acc(1, 0, 23'h201, 8'h00, 8'h66, 22, t, t + 16);
`endif
        go();
        clear_all();
        wait_idle("rotation");

        // Reset during WAIT_DONE with clients 1 and 2 pending.
        go();
        t = cyc;
        req(0, 1, 0, 23'h300, 8'h00);
        expect_acc(0, 0, 23'h300, 8'h00, 8'h88, 8, t, t + 2);
        go();
        clear_all();
        wait_idle("pre_reset");
        go();
        t = cyc;
        req(1, 1, 0, 23'h301, 8'h00);
        req(2, 1, 0, 23'h302, 8'h00);
        begin
            host_t h;
            h.addr = 23'h301;
            h.wr   = 1'b0;
            h.wd   = 8'h00;
            h.cyc  = t + 2;
            hq.push_back(h);
        end
        go();
        clear_all();
        repeat (3) go();
        in_rst = 1'b1;
        rst = 1'b1;
        go();
        rst = 1'b0;
        check_reset_state("mid_reset");
        chk("mid_reset_hq_drained", hq.size(), 0);
        for (int k = 0; k < N; k++) exp_rd[k] = 8'h00;
        go();
        in_rst = 1'b0;

        go();
        t = cyc;
        req(0, 1, 0, 23'h303, 8'h00);
        req(1, 1, 0, 23'h304, 8'h00);
        expect_acc(0, 0, 23'h303, 8'h00, 8'hAB, 8, t, t + 2);
        expect_acc(1, 0, 23'h304, 8'h00, 8'hCD, 15, t, t + 9);
        go();
        clear_all();
        wait_idle("post_reset");

        chk("final_rdata2", 32'(bus.o_RDATA[2]), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
